seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of the fixed-pattern `seq_detector`. It samples one serial bit per qualified clock and pulses `w` when the most recent `len` bits equal a runtime-programmable pattern. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits on the serial input path and feeds downstream control and status logic.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `len`.
- `CNT_W`, 8: width of the match counter.
- `RST_PATTERN`, `'b101`: pattern loaded at reset (MAX_LEN bits, right-aligned).
- `RST_LEN`, 3: length loaded at reset.
- `RST_OVERLAP`, 1: overlap mode loaded at reset.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `a`, input, 1: serial data bit.
- `valid`, input, 1: `a` is sampled on this edge.
- `cfg_load`, input, 1: latch `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`, input, MAX_LEN: new pattern. Bit `[len-1]` is the first bit received; bit `[0]` is the last.
- `cfg_len`, input, LEN_W: new pattern length.
- `cfg_overlap`, input, 1: 1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr`, input, 1: synchronous clear of `match_cnt`.
- `w`, output, 1: registered one-cycle match pulse.
- `match_cnt`, output, CNT_W: saturating count of matches.

## Operation
- State:
  - `hist[MAX_LEN-1:0]`: shift register; the newest bit enters at `[0]`.
  - `fill`: number of valid bits in `hist`, saturating at MAX_LEN.
  - Configuration registers: `pat`, `len_r`, `ovl_r`.
- Effective length:
  - `cfg_len > MAX_LEN` is clamped to MAX_LEN when it is loaded.
  - `len_r == 0` disables detection: `w` stays 0 and `hist` keeps shifting.
- Per-edge priority, highest first:
  1. `cfg_load`: latch the configuration, clear `hist` and `fill`, and set `w` to 0. Any bit presented on the same edge is discarded.
  2. `valid`: compute `hist' = {hist[MAX_LEN-2:0], a}` and `fill' = min(fill+1, MAX_LEN)`.
     - Match condition: `fill' >= len_r` and `hist'[len_r-1:0] == pat[len_r-1:0]`.
     - On a match, `w` is set to 1.
     - On a match with `ovl_r == 0`, `fill` is set to 0 so the matched bits cannot be reused.
  3. Neither: `hist` and `fill` hold, and `w` is set to 0.
- Counter:
  - On a match, `match_cnt` increments and saturates at 2^CNT_W−1.
  - `cnt_clr` overrides an increment on the same edge: the count becomes 0 and `w` still pulses.
- Gaps in `valid` do not break a sequence: bits separated by idle cycles are treated as contiguous.

## Timing
- Reset values: `w`=0, `match_cnt`=0, `hist`=0, `fill`=0, `pat`=RST_PATTERN, `len_r`=RST_LEN, `ovl_r`=RST_OVERLAP.
- Latency:
  - `w` rises after the edge that samples the last pattern bit and stays high for exactly one cycle.
  - `match_cnt` updates on the same edge as `w`.
- Back-to-back matches on consecutive valid bits are possible in overlap mode. In that case `w` stays high for several cycles, one per match.
- Assertion of `rst_n` mid-sequence clears all state at once and discards the partial match.
- A new configuration takes effect for the bit sampled on the edge after `cfg_load`.

## Structure
- Package `seq_det_pkg` holds:
  - the `clog2`-based width helpers;
  - the mode constants `MODE_OVERLAP` = 1 and `MODE_NONOVERLAP` = 0.
- One sub-module, `sat_counter`, implements the CNT_W saturating counter with `inc` and `clr` inputs and asynchronous active-low reset.
- The rest is a single always block for state plus a masked comparator: `hist'` and `pat` are compared under a mask of `len_r` ones.

## Test plan
- Reset defaults, stream 1,0,1,1,0,0,1,1,0,1,1 with `valid`=1 → `w` pulses after bits 3 and 10 only; `match_cnt`=2.
- Non-overlap: load pattern `101`, len 3, overlap 0, then stream 1,0,1,0,1 → one pulse, after bit 3; `match_cnt`=1.
  - Repeat with overlap 1 → pulses after bits 3 and 5; `match_cnt`=2.
- Length and gaps: load `1101`, len 4, then present 1,1,0,1 with `valid` low for 2 cycles between each bit → a single pulse after the 4th valid bit, and no pulse during idle cycles.
- Saturation and clear, with CNT_W=2:
  - Overlap pattern `11`, stream six 1s → 5 matches; `match_cnt` saturates at 3.
  - `cnt_clr` coincident with a match → `match_cnt`=0 and `w`=1.
- Reset and reconfig mid-operation:
  - Drive `rst_n` low after bits 1,0 of `101`, then send 1 → no pulse.
  - `cfg_load` on the edge carrying a completing bit → no pulse, and `hist` is cleared.
  - `cfg_len`=12 with MAX_LEN=8 → behaves as len 8.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    // Width able to hold the values 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-programmable pattern, length and overlap mode.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = len_width(MAX_LEN),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b101,
    parameter int                 RST_LEN     = 3,
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a,
    input  logic               valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               w,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_nxt;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_clamped;
    logic               ovl_r;
    logic               match;
    logic               unused_hist_msb;

    // The oldest history bit only ever shifts out; no window can reach it.
    assign unused_hist_msb = hist[MAX_LEN-1];

    assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    always_comb begin
        hist_nxt = {hist[MAX_LEN-2:0], a};
        fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_r));
        end
        // Only the newest len_r bits take part; a zero length never matches.
        match = valid && !cfg_load && (len_r != '0) && (fill_nxt >= len_r) &&
                (((hist_nxt ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= RST_PATTERN;
            len_r <= LEN_W'(RST_LEN);
            ovl_r <= RST_OVERLAP;
            w     <= 1'b0;
        end else if (cfg_load) begin
            pat   <= cfg_pattern;
            len_r <= len_clamped;
            ovl_r <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
            w     <= 1'b0;
        end else if (valid) begin
            hist <= hist_nxt;
            // Non-overlap mode forgets the matched bits so they cannot start the next match.
            fill <= (match && ovl_r == MODE_NONOVERLAP) ? '0 : fill_nxt;
            w    <= match;
        end else begin
            w <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (MAX_LEN=8, CNT_W=2 so saturation is reachable).
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               a;
    logic               valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               w;
    logic [CNT_W-1:0]   match_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detector_param #(
        .MAX_LEN     (MAX_LEN),
        .CNT_W       (CNT_W),
        .RST_PATTERN (8'b101),
        .RST_LEN     (3),
        .RST_OVERLAP (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .valid       (valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .w           (w),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        a     = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic idle();
        valid = 1'b0;
        step();
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    // Send n bits, first bit = bits[n-1]; exp_w[n-1-i] is the pulse expected after bit i.
    task automatic stream(input string tag, input logic [15:0] bits, input logic [15:0] exp_w,
                          input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i]);
            check($sformatf("%s_w%0d", tag, i + 1), w, exp_w[n-1-i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        repeat (3) step();
        check("rst_w", w, 0);
        check("rst_cnt", match_cnt, 0);
        rst_n = 1'b1;
        step();

        // Reset defaults: 101, overlap; pulses after bits 3 and 10.
        stream("dflt", 16'b101_1001_1011, 16'b001_0000_0010, 11);
        check("dflt_cnt", match_cnt, 2);
        idle();
        check("dflt_idle_w", w, 0);
        clear_cnt();
        check("clr_cnt", match_cnt, 0);

        // Non-overlap 101 on 10101: one pulse.
        load(8'b101, 4'd3, 1'b0);
        stream("novl", 16'b10101, 16'b00100, 5);
        check("novl_cnt", match_cnt, 1);
        clear_cnt();

        // Overlap 101 on 10101: two pulses.
        load(8'b101, 4'd3, 1'b1);
        stream("ovl", 16'b10101, 16'b00101, 5);
        check("ovl_cnt", match_cnt, 2);
        clear_cnt();

        // 1101 with two idle cycles between bits.
        load(8'b1101, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] bits;
            bits = 4'b1101;
            send_bit(bits[3-i]);
            check($sformatf("gap_w%0d", i + 1), w, (i == 3) ? 1 : 0);
            idle();
            check($sformatf("gap_idle%0d_a", i + 1), w, 0);
            idle();
            check($sformatf("gap_idle%0d_b", i + 1), w, 0);
        end
        check("gap_cnt", match_cnt, 1);
        clear_cnt();

        // Saturation: 11 overlapping on six 1s gives 5 matches, count stops at 3.
        load(8'b11, 4'd2, 1'b1);
        stream("sat", 16'b11_1111, 16'b01_1111, 6);
        check("sat_cnt", match_cnt, 3);
        cnt_clr = 1'b1;
        send_bit(1'b1);
        cnt_clr = 1'b0;
        check("clr_match_w", w, 1);
        check("clr_match_cnt", match_cnt, 0);
        send_bit(1'b1);
        check("post_clr_cnt", match_cnt, 1);

        // Async reset mid-sequence discards the partial match and restores defaults.
        send_bit(1'b1);
        send_bit(1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", match_cnt, 0);
        check("async_rst_w", w, 0);
        #2 rst_n = 1'b1;
        step();
        stream("after_rst", 16'b101, 16'b001, 3);
        check("after_rst_cnt", match_cnt, 1);

        // cfg_load on the completing edge discards the bit and clears history.
        send_bit(1'b1);
        send_bit(1'b0);
        a = 1'b1; valid = 1'b1;
        load(8'b101, 4'd3, 1'b1);
        valid = 1'b0;
        check("load_edge_w", w, 0);
        stream("post_load", 16'b101, 16'b001, 3);
        check("post_load_cnt", match_cnt, 2);

        // Length 12 clamps to 8.
        load(8'hA6, 4'd12, 1'b1);
        stream("clamp", 16'hA6, 16'h01, 8);
        check("clamp_cnt", match_cnt, 3);
        clear_cnt();

        // Length 0 disables detection.
        load(8'h00, 4'd0, 1'b1);
        stream("len0", 16'b1010, 16'b0000, 4);
        check("len0_cnt", match_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
